// File: rtl/pmod_pattern_gen_pkg.sv
// pmod_pattern_gen_pkg: shared FSM states, per-count pattern totals and mask helpers
package pmod_pattern_gen_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP, FINISH} state_t;
  // number of 3-bit masks with popcount 0..3
  localparam logic [2:0] PAT_CNT [4] = '{3'd1, 3'd3, 3'd3, 3'd1};
  function automatic logic [1:0] popcount3(input logic [2:0] m);
    return 2'(m[0]) + 2'(m[1]) + 2'(m[2]);
  endfunction
  // smallest mask >= lo whose popcount equals c; search is combinational so skips cost no cycles
  function automatic logic [2:0] next_mask(input logic [3:0] lo, input logic [1:0] c);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--)
      if (4'(i) >= lo && popcount3(3'(i)) == c) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/pmod_hold_timer.sv
// pmod_hold_timer: loadable down-counter, expire is high in the last cycle of a loaded length
// ports: clk, rst_n (async active-low), load/len start a phase, expire flags its final cycle
module pmod_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? len : (cnt != '0 ? cnt - W'(1) : cnt);
  assign expire = cnt == W'(1);
endmodule

// File: rtl/pmod_pattern_gen.sv
// pmod_pattern_gen: sweeps every 3-button press pattern with a requested popcount onto active-low pins
// ports: clk, rst_n (async active-low); req_valid/req_count/req_ready request handshake; abort cancels;
//        pmod1..3 emulated buttons (0 = pressed); exp_d2:exp_d1 expected count; busy; done pulse
module pmod_pattern_gen
  import pmod_pattern_gen_pkg::*;
#(
  parameter int HOLD_CYCLES = 12000000,
  parameter int GAP_CYCLES  = 1200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_count,
  output logic       req_ready,
  input  logic       abort,
  output logic       pmod1,
  output logic       pmod2,
  output logic       pmod3,
  output logic       exp_d1,
  output logic       exp_d2,
  output logic       busy,
  output logic       done
);
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  state_t state;
  logic [2:0] mask, pins, first, nxt;
  logic [1:0] cnt, idx, expc;
  logic expire, load, last;
  logic [CW-1:0] len;
  assign first = next_mask(4'd0, req_count);
  assign nxt = next_mask({1'b0, mask} + 4'd1, cnt);
  assign last = {1'b0, idx} == PAT_CNT[cnt] - 3'd1;
  assign load = state == IDLE ? req_valid : (state == DRIVE || state == GAP) && !abort && expire;
  // only a DRIVE->GAP transition loads the gap length; everything else starts a hold
  assign len = state == DRIVE && GAP_CYCLES > 0 ? CW'(GAP_CYCLES) : CW'(HOLD_CYCLES);
  assign {pmod3, pmod2, pmod1} = pins;
  assign {exp_d2, exp_d1} = expc;
  pmod_hold_timer #(.W(CW)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .len(len), .expire(expire)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mask <= '0;
      cnt <= '0;
      idx <= '0;
      pins <= 3'b111;
      expc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          state <= DRIVE;
          cnt <= req_count;
          mask <= first;
          idx <= '0;
          pins <= ~first;
          expc <= req_count;
          busy <= 1'b1;
          req_ready <= 1'b0;
        end
        DRIVE, GAP: if (abort) begin
          state <= IDLE;
          pins <= 3'b111;
          expc <= '0;
          busy <= 1'b0;
          req_ready <= 1'b1;
        end else if (expire) begin
          if (state == DRIVE && GAP_CYCLES > 0) begin
            state <= GAP;
            pins <= 3'b111;
            expc <= '0;
          end else if (last) begin
            state <= FINISH;
            pins <= 3'b111;
            expc <= '0;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            state <= DRIVE;
            mask <= nxt;
            idx <= idx + 2'd1;
            pins <= ~nxt;
            expc <= cnt;
          end
        end
        default: begin
          state <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
endmodule
